sa_stream_wrapper: RTL and testbench

SA_STREAM_WRAPPER -- requirements
Module: sa_stream_wrapper

---
 rtl/sa_stream_wrapper.sv | 223 ++++++++++++++++++++++
 tb/tb_sa_stream_wrapper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sa_stream_wrapper.sv
// Output-stationary SA_R x SA_C systolic matrix multiplier fed by streaming X-column / W-row beats.
// Latency: K + SA_R + SA_C cycles from the start pulse to the O_OUT_VLD pulse when no beat is missing.
// Backpressure: O_RDY is high only while loading; a missing beat freezes the whole array (bubble-tolerant).
//
// Element packing: I_X_VEC[i*D_W +: D_W] is X row i, I_W_VEC[j*D_W +: D_W] is W column j,
// and O_OUT[(i*SA_C+j)*D_W +: D_W] is result element (i, j).
module sa_stream_wrapper #(
  parameter int D_W   = 16,
  parameter int FRAC  = 13,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_MAX = 128,
  localparam int KW   = $clog2(K_MAX + 1)
) (
  input  logic                     I_CLK,
  input  logic                     I_SYNC_RSTN,
  input  logic                     I_START,
  input  logic [KW-1:0]            I_K_DIM,
  input  logic                     I_ACC_MODE,
  input  logic                     I_VLD,
  output logic                     O_RDY,
  input  logic [SA_R*D_W-1:0]      I_X_VEC,
  input  logic [SA_C*D_W-1:0]      I_W_VEC,
  output logic                     O_BUSY,
  output logic                     O_OUT_VLD,
  output logic [SA_R*SA_C*D_W-1:0] O_OUT
);

  // Accumulator is wide enough for K_MAX full-precision products without wrapping.
  localparam int PW      = 2 * D_W;
  localparam int AW      = 2 * D_W + $clog2(K_MAX);
  localparam int DRAIN_N = SA_R + SA_C - 1;
  localparam int DCW     = $clog2(SA_R + SA_C);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-D_W+1){1'b1}}, {(D_W-1){1'b0}}};
  localparam logic [D_W-1:0]       OUT_MAX = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0]       OUT_MIN = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        beat_q;
  logic [DCW-1:0]       drain_q;
  logic [KW-1:0]        k_clamp;
  logic                 start_job;
  logic                 in_load;
  logic                 accept;
  logic                 shift;

  logic signed [D_W-1:0] x_in   [SA_R];
  logic signed [D_W-1:0] x_edge [SA_R];
  logic signed [D_W-1:0] w_in   [SA_C];
  logic signed [D_W-1:0] w_edge [SA_C];
  logic signed [D_W-1:0] x_q    [SA_R][SA_C];
  logic signed [D_W-1:0] w_q    [SA_R][SA_C];
  logic signed [AW-1:0]  acc_q  [SA_R][SA_C];
  logic signed [AW-1:0]  acc_d  [SA_R][SA_C];
  logic [SA_R*SA_C*D_W-1:0] out_q;

  // Floor shift back to the element format, clipped to the representable range.
  function automatic logic [D_W-1:0] sat_shift(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX)      sat_shift = OUT_MAX;
    else if (s < SAT_MIN) sat_shift = OUT_MIN;
    else                  sat_shift = D_W'(s);
  endfunction

  assign k_clamp   = (I_K_DIM > KW'(K_MAX)) ? KW'(K_MAX) : I_K_DIM;
  assign start_job = (state_q == S_IDLE) && I_START;
  assign in_load   = (state_q == S_LOAD);
  assign accept    = in_load && I_VLD;
  assign shift     = accept || (state_q == S_DRAIN);

  // State register
  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state: START only matters in IDLE; drain runs a fixed number of shifts
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (I_START) state_d = (k_clamp == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (accept && (beat_q == k_q - KW'(1))) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DCW'(DRAIN_N - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    O_RDY     = 1'b0;
    O_BUSY    = 1'b1;
    O_OUT_VLD = 1'b0;
    case (state_q)
      S_IDLE:  O_BUSY    = 1'b0;
      S_LOAD:  O_RDY     = 1'b1;
      S_DONE:  O_OUT_VLD = 1'b1;
      default: ;
    endcase
  end

  // Job counters: latched depth, accepted beats, drain shifts
  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN) begin
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else if (start_job) begin
      k_q     <= k_clamp;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      if (accept) beat_q <= beat_q + KW'(1);
      if (state_q == S_DRAIN) drain_q <= drain_q + DCW'(1);
    end
  end

  // Edge inputs: live beat data while loading, zeros while draining
  always_comb begin
    for (int i = 0; i < SA_R; i++) x_in[i] = in_load ? I_X_VEC[i*D_W +: D_W] : '0;
    for (int j = 0; j < SA_C; j++) w_in[j] = in_load ? I_W_VEC[j*D_W +: D_W] : '0;
  end

  for (genvar gi = 0; gi < SA_R; gi++) begin : g_x_skew
    if (gi == 0) begin : g_direct
      assign x_edge[gi] = x_in[gi];
    end else begin : g_delay
      logic signed [D_W-1:0] sk_q [gi];
      // X row delay line of gi stages, advancing only with the array
      always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RSTN || start_job) begin
          for (int t = 0; t < gi; t++) sk_q[t] <= '0;
        end else if (shift) begin
          sk_q[0] <= x_in[gi];
          for (int t = 1; t < gi; t++) sk_q[t] <= sk_q[t-1];
        end
      end
      assign x_edge[gi] = sk_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < SA_C; gj++) begin : g_w_skew
    if (gj == 0) begin : g_direct
      assign w_edge[gj] = w_in[gj];
    end else begin : g_delay
      logic signed [D_W-1:0] sk_q [gj];
      // W column delay line of gj stages, advancing only with the array
      always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RSTN || start_job) begin
          for (int t = 0; t < gj; t++) sk_q[t] <= '0;
        end else if (shift) begin
          sk_q[0] <= w_in[gj];
          for (int t = 1; t < gj; t++) sk_q[t] <= sk_q[t-1];
        end
      end
      assign w_edge[gj] = sk_q[gj-1];
    end
  end

  // PE operand registers: X travels right, W travels down, one PE per shift
  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN || start_job) begin
      for (int i = 0; i < SA_R; i++) begin
        for (int j = 0; j < SA_C; j++) begin
          x_q[i][j] <= '0;
          w_q[i][j] <= '0;
        end
      end
    end else if (shift) begin
      for (int i = 0; i < SA_R; i++) begin
        x_q[i][0] <= x_edge[i];
        for (int j = 1; j < SA_C; j++) x_q[i][j] <= x_q[i][j-1];
      end
      for (int j = 0; j < SA_C; j++) begin
        w_q[0][j] <= w_edge[j];
        for (int i = 1; i < SA_R; i++) w_q[i][j] <= w_q[i-1][j];
      end
    end
  end

  // Accumulator next value: cleared at job start unless accumulating, MAC on each shift
  always_comb begin
    for (int i = 0; i < SA_R; i++) begin
      for (int j = 0; j < SA_C; j++) begin
        acc_d[i][j] = acc_q[i][j];
        if (start_job && !I_ACC_MODE) acc_d[i][j] = '0;
        else if (shift)
          acc_d[i][j] = acc_q[i][j] + AW'(PW'(x_q[i][j]) * PW'(w_q[i][j]));
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge I_CLK) begin
    for (int i = 0; i < SA_R; i++) begin
      for (int j = 0; j < SA_C; j++) begin
        if (!I_SYNC_RSTN) acc_q[i][j] <= '0;
        else              acc_q[i][j] <= acc_d[i][j];
      end
    end
  end

  // Result register loads from the final accumulator value as DONE is entered,
  // so the data is already stable during the O_OUT_VLD cycle
  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN) begin
      out_q <= '0;
    end else if (state_d == S_DONE) begin
      for (int i = 0; i < SA_R; i++) begin
        for (int j = 0; j < SA_C; j++) out_q[(i*SA_C+j)*D_W +: D_W] <= sat_shift(acc_d[i][j]);
      end
    end
  end

  assign O_OUT = out_q;

endmodule

// File: tb/tb_sa_stream_wrapper.sv
// Directed bench for sa_stream_wrapper on a 4x4 array with K_MAX=8.
// Job vectors come from a table; reset and START corner cases are hand-written sequences.
// Outputs are sampled 1 time unit after each rising edge, where inputs are also driven.
module tb_sa_stream_wrapper;
  localparam int D_W = 16;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int KM  = 8;
  localparam int KW  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [KW-1:0]     k_dim;
  logic              acc_mode;
  logic              vld;
  logic              rdy;
  logic [R*D_W-1:0]  xv;
  logic [C*D_W-1:0]  wv;
  logic              busy;
  logic              out_vld;
  logic [R*C*D_W-1:0] out;

  always #5 clk = ~clk;

  sa_stream_wrapper #(.D_W(D_W), .FRAC(13), .SA_R(R), .SA_C(C), .K_MAX(KM)) dut (
    .I_CLK(clk), .I_SYNC_RSTN(rstn), .I_START(start), .I_K_DIM(k_dim),
    .I_ACC_MODE(acc_mode), .I_VLD(vld), .O_RDY(rdy), .I_X_VEC(xv), .I_W_VEC(wv),
    .O_BUSY(busy), .O_OUT_VLD(out_vld), .O_OUT(out)
  );

  typedef struct {
    string       nm;
    int          k;
    bit          acc;
    bit          bubble;
    bit          x_ident;
    logic [15:0] x_val;
    bit          w_mat;
    logic [15:0] w_val;
    bit          exp_w;
    logic [15:0] exp_val;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] w_mat [4][4];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(string nm, int k, bit acc, bit bubble, bit x_ident,
                              logic [15:0] x_val, bit wm, logic [15:0] w_val,
                              bit exp_w, logic [15:0] exp_val, int exp_lat);
    vec_t v;
    v.nm = nm; v.k = k; v.acc = acc; v.bubble = bubble; v.x_ident = x_ident;
    v.x_val = x_val; v.w_mat = wm; v.w_val = w_val; v.exp_w = exp_w;
    v.exp_val = exp_val; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_beat(input vec_t v, input int idx);
    for (int i = 0; i < R; i++)
      xv[i*D_W +: D_W] = v.x_ident ? ((i == idx) ? v.x_val : 16'h0000) : v.x_val;
    for (int j = 0; j < C; j++)
      wv[j*D_W +: D_W] = v.w_mat ? w_mat[idx % R][j] : v.w_val;
  endtask

  // Start at cycle 0, feed beats while ready, find the result pulse, check everything.
  task automatic run_vec(input vec_t v);
    int c, idx, lat;
    bit rdy_seen, accepted;
    k_dim = KW'(v.k); acc_mode = v.acc; start = 1'b1; vld = 1'b0;
    idx = 0; lat = -1; rdy_seen = 1'b0;
    drive_beat(v, 0);
    tick();
    start = 1'b0;
    c = 1;
    while (lat < 0 && c <= 60) begin
      if (out_vld) lat = c;
      else begin
        if (rdy) rdy_seen = 1'b1;
        vld = !v.bubble || (c % 2 == 0);
        drive_beat(v, idx);
        accepted = vld && rdy;
        tick();
        if (accepted) idx++;
        c++;
      end
    end
    vld = 1'b0;
    chk({v.nm, " latency"}, lat, v.exp_lat);
    chk({v.nm, " rdy_seen"}, int'(rdy_seen), int'(v.k != 0));
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        chk($sformatf("%s out[%0d][%0d]", v.nm, i, j), int'(out[(i*C+j)*D_W +: D_W]),
            int'(v.exp_w ? w_mat[i][j] : v.exp_val));
    tick();
    chk({v.nm, " vld_pulse_end"}, int'(out_vld), 0);
    chk({v.nm, " idle_after"}, int'(busy), 0);
  endtask

  initial begin
    vec_t r;
    int   lat;

    w_mat[0][0] = 16'h0001; w_mat[0][1] = 16'h7FFF; w_mat[0][2] = 16'h8000; w_mat[0][3] = 16'h1234;
    w_mat[1][0] = 16'hFFFF; w_mat[1][1] = 16'h2000; w_mat[1][2] = 16'hE000; w_mat[1][3] = 16'h0ABC;
    w_mat[2][0] = 16'h4321; w_mat[2][1] = 16'hC000; w_mat[2][2] = 16'h0000; w_mat[2][3] = 16'h5555;
    w_mat[3][0] = 16'hAAAA; w_mat[3][1] = 16'h0100; w_mat[3][2] = 16'hFEDC; w_mat[3][3] = 16'h3FFF;

    //            name        K  acc bub xid x_val     wm w_val     expw exp_val   lat
    vecs[0] = mk("ident",     4, 0, 0, 1, 16'h2000, 1, 16'h0000, 1, 16'h0000, 12);
    vecs[1] = mk("sat_pos",   8, 0, 0, 0, 16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF, 16);
    vecs[2] = mk("bubble",    4, 0, 1, 1, 16'h2000, 1, 16'h0000, 1, 16'h0000, 16);
    vecs[3] = mk("sat_neg",   8, 0, 0, 0, 16'h7FFF, 0, 16'h8000, 0, 16'h8000, 16);
    vecs[4] = mk("acc_a",     4, 0, 0, 1, 16'h2000, 0, 16'h1000, 0, 16'h1000, 12);
    vecs[5] = mk("acc_b",     4, 1, 0, 1, 16'h2000, 0, 16'h1000, 0, 16'h2000, 12);
    vecs[6] = mk("clamp",    13, 0, 0, 0, 16'h0400, 0, 16'h2000, 0, 16'h2000, 16);
    vecs[7] = mk("k0_keep",   0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h2000, 1);
    vecs[8] = mk("k0_clear",  0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1);
    vecs[9] = mk("floor",     2, 0, 0, 0, 16'h0001, 0, 16'hFFFF, 0, 16'hFFFF, 10);

    rstn = 1'b0; start = 1'b0; acc_mode = 1'b0; vld = 1'b0; k_dim = '0; xv = '0; wv = '0;
    tick();
    tick();
    chk("reset rdy", int'(rdy), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset out_vld", int'(out_vld), 0);
    chk("reset out_nonzero", int'(out != '0), 0);

    // Reset wins over a simultaneous start
    rstn = 1'b1;
    tick();
    start = 1'b1; k_dim = 4'd4; rstn = 1'b0;
    tick();
    chk("rst_over_start busy", int'(busy), 0);
    rstn = 1'b1; start = 1'b0;
    tick();
    chk("rst_over_start stays idle", int'(busy), 0);

    for (int n = 0; n < 10; n++) run_vec(vecs[n]);

    // START held high through a whole K=2 job: ignored while busy and in the DONE cycle
    k_dim = 4'd2; acc_mode = 1'b0; start = 1'b1; vld = 1'b1;
    xv = {4{16'h2000}}; wv = {4{16'h0800}};
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (out_vld) lat = c;
    end
    chk("start_held latency", lat, 10);
    chk("start_held out[0][0]", int'(out[0 +: D_W]), 16'h1000);
    chk("start_held out[3][3]", int'(out[15*D_W +: D_W]), 16'h1000);
    tick();
    chk("start_held idle after done", int'(busy), 0);
    start = 1'b0; vld = 1'b0;
    tick();
    chk("start_held no restart", int'(busy), 0);

    // Reset in the middle of draining, then a fresh accumulate-mode job
    r = vecs[4];
    k_dim = 4'd4; acc_mode = 1'b0; start = 1'b1;
    drive_beat(r, 0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      vld = 1'b1;
      drive_beat(r, c - 1);
      tick();
    end
    vld = 1'b0;
    chk("mid_drain busy", int'(busy), 1);
    rstn = 1'b0;
    tick();
    chk("mid_drain reset busy", int'(busy), 0);
    chk("mid_drain reset rdy", int'(rdy), 0);
    chk("mid_drain reset out_nonzero", int'(out != '0), 0);
    rstn = 1'b1;
    r.nm = "post_reset_acc1"; r.acc = 1'b1; r.exp_val = 16'h1000;
    run_vec(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
